tohost_monitor: RTL and testbench

Synthesizable memory-mapped test-status unit on the CPU data-memory store bus, alongside the dmem BRAM. It decodes stores to the riscv-tests `tohost` word, latches pass/fail/timeout into a sticky status, counts run cycles, and offers a 1-cycle-latency readback port that the dmem read mux selects on `hit`. The block gives hardware (FPGA LEDs/ILA) and benches a single verdict source.

---
 rtl/tohost_pkg.sv | 15 +
 rtl/tohost_monitor_if.sv | 13 +
 rtl/tohost_watchdog.sv | 30 +++
 rtl/tohost_monitor.sv | 84 ++++++++
 tb/tb_tohost_monitor.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/tohost_pkg.sv
// tohost_pkg: shared state encoding, status word layout and default addresses for tohost_monitor
package tohost_pkg;
    localparam logic [31:0] TOHOST_ADDR_DEF = 32'h0000_1000;
    localparam logic [31:0] STATUS_ADDR_DEF = 32'h0000_1004;
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_e;
    typedef struct packed {
        logic [29:0] rsvd;
        state_e      state;
    } status_t;
endpackage

// File: rtl/tohost_monitor_if.sv
// tohost_monitor_if: CPU data-memory bus as seen by tohost_monitor
//   mem_addr/mem_we/mem_wdata/mem_re : CPU -> monitor (byte address, byte strobes, lane-aligned data, load request)
//   mem_rdata/hit                    : monitor -> CPU (registered readback, combinational address match)
interface tohost_monitor_if;
    logic [31:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        hit;
    modport master (output mem_addr, mem_we, mem_wdata, mem_re, input mem_rdata, hit);
    modport slave (input mem_addr, mem_we, mem_wdata, mem_re, output mem_rdata, hit);
endinterface

// File: rtl/tohost_watchdog.sv
// tohost_watchdog: saturating run-cycle counter with optional timeout compare (TOHOST_TIMEOUT_EN)
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   run              : count enable, high while the monitor is in RUN
//   cycle_count      : edges spent in RUN, saturating at all-ones
//   timeout          : high on the RUN edge where cycle_count == TIMEOUT_CYCLES-1
module tohost_watchdog #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_W          = 32
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             run,
    output logic [CNT_W-1:0] cycle_count,
    output logic             timeout
);
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("tohost_watchdog: TIMEOUT_CYCLES must be at least 2");
    end
    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            cycle_count <= '0;
        else if (run && !(&cycle_count))
            cycle_count <= cycle_count + 1'b1;
    end
`ifdef TOHOST_TIMEOUT_EN
    assign timeout = run && (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif
endmodule

// File: rtl/tohost_monitor.sv
// tohost_monitor: decodes riscv-tests tohost stores into a sticky pass/fail/timeout verdict with readback
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   bus              : data-memory bus (slave side); hit selects this block in the dmem read mux
//   done, pass       : state is not RUN / state is PASS
//   fail_testnum     : tohost[31:1] of the failing store, 0 unless FAIL
//   cycle_count      : edges spent in RUN
//   Watchdog compiled in only when TOHOST_TIMEOUT_EN is defined.
module tohost_monitor
    import tohost_pkg::*;
#(
    parameter logic [31:0] TOHOST_ADDR    = TOHOST_ADDR_DEF,
    parameter logic [31:0] STATUS_ADDR    = STATUS_ADDR_DEF,
    parameter int          TIMEOUT_CYCLES = 100000,
    parameter int          CNT_W          = 32
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    tohost_monitor_if.slave  bus,
    output logic             done,
    output logic             pass,
    output logic [30:0]      fail_testnum,
    output logic [CNT_W-1:0] cycle_count
);
    state_e      state_q, state_d;
    logic [31:0] tohost_q, merged, rd_mux;
    logic [30:0] testnum_d;
    logic        store, timeout;
    status_t     status;

    assign store  = (bus.mem_addr == TOHOST_ADDR) && (|bus.mem_we);
    assign bus.hit = (bus.mem_addr == TOHOST_ADDR) || (bus.mem_addr == STATUS_ADDR);
    assign done   = state_q != ST_RUN;
    assign pass   = state_q == ST_PASS;
    assign status = '{rsvd: '0, state: state_q};
    assign rd_mux = bus.mem_addr == TOHOST_ADDR ? tohost_q :
                    bus.mem_addr == STATUS_ADDR ? status : '0;

    always_comb begin
        merged = tohost_q;
        for (int i = 0; i < 4; i++)
            if (bus.mem_we[i]) merged[8*i +: 8] = bus.mem_wdata[8*i +: 8];
    end

    // A verdict store outranks a timeout landing on the same edge.
    always_comb begin
        state_d   = state_q;
        testnum_d = fail_testnum;
        if (state_q == ST_RUN) begin
            if (store && merged == 32'd1)
                state_d = ST_PASS;
            else if (store && merged[0]) begin
                state_d   = ST_FAIL;
                testnum_d = merged[31:1];
            end else if (timeout)
                state_d = ST_TIMEOUT;
        end
    end

    // Readback samples tohost_q before this edge's store lands.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q       <= ST_RUN;
            tohost_q      <= '0;
            fail_testnum  <= '0;
            bus.mem_rdata <= '0;
        end else begin
            state_q      <= state_d;
            fail_testnum <= testnum_d;
            if (store && state_q == ST_RUN) tohost_q <= merged;
            if (bus.mem_re) bus.mem_rdata <= rd_mux;
        end
    end

    tohost_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_watchdog (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .run        (state_q == ST_RUN),
        .cycle_count(cycle_count),
        .timeout    (timeout)
    );
endmodule

// File: tb/tb_tohost_monitor.sv
// tb_tohost_monitor: vector table, corner sequences and randomized run against a behavioural model
module tb_tohost_monitor;
    localparam logic [31:0] TH = 32'h0000_1000;
    localparam logic [31:0] ST = 32'h0000_1004;
    localparam int TO = 16;
    localparam int CW = 8;
    localparam int CMAX = (1 << CW) - 1;
`ifdef TOHOST_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic          done, pass;
    logic [30:0]   fail_testnum;
    logic [CW-1:0] cycle_count;
    int            checks = 0;
    int            errors = 0;

    int            m_state, m_cnt;
    logic [31:0]   m_th, m_rd;
    logic [30:0]   m_tn;

    typedef struct {
        logic r; logic [31:0] a; logic [3:0] w; logic [31:0] d; logic e;
        logic hit; logic dn; logic ps; logic [30:0] tn; logic [31:0] rd; int cnt;
    } vec_t;
    vec_t tbl[15];

    tohost_monitor_if bus();

    tohost_monitor #(
        .TOHOST_ADDR   (TH),
        .STATUS_ADDR   (ST),
        .TIMEOUT_CYCLES(TO),
        .CNT_W         (CW)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .bus         (bus),
        .done        (done),
        .pass        (pass),
        .fail_testnum(fail_testnum),
        .cycle_count (cycle_count)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", n, act, exp);
        end
    endtask

    // One clock: drive, check hit, advance the model by the spec rules, compare all outputs.
    task automatic step(input logic r, input logic [31:0] a, input logic [3:0] w,
                        input logic [31:0] d, input logic e, output logic h);
        logic [31:0] mg;
        int ns;
        sys_rst = r; bus.mem_addr = a; bus.mem_we = w; bus.mem_wdata = d; bus.mem_re = e;
        #1;
        h = bus.hit;
        chk("hit", h, (a == TH || a == ST));
        @(posedge sys_clk);
        mg = m_th;
        for (int i = 0; i < 4; i++) if (w[i]) mg[8*i +: 8] = d[8*i +: 8];
        if (r) begin
            m_state = 0; m_cnt = 0; m_th = 0; m_rd = 0; m_tn = 0;
        end else begin
            if (e) m_rd = (a == TH) ? m_th : (a == ST) ? 32'(m_state) : 32'd0;
            if (m_state == 0) begin
                ns = 0;
                if (a == TH && w != 0) begin
                    m_th = mg;
                    if (mg == 1) ns = 1;
                    else if (mg[0]) begin ns = 2; m_tn = mg[31:1]; end
                end
                if (TO_EN && ns == 0 && m_cnt == TO - 1) ns = 3;
                if (m_cnt < CMAX) m_cnt++;
                m_state = ns;
            end
        end
        #1;
        chk("done", done, m_state != 0);
        chk("pass", pass, m_state == 1);
        chk("testnum", fail_testnum, m_tn);
        chk("count", cycle_count, 64'(m_cnt));
        chk("rdata", bus.mem_rdata, m_rd);
    endtask

    task automatic idle(input int n);
        logic h;
        repeat (n) step(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, h);
    endtask

    initial begin
        logic h;
        logic [31:0] a, d;
        logic [3:0] w;
        m_state = 0; m_cnt = 0; m_th = 0; m_rd = 0; m_tn = 0;
        //           r   addr          we    wdata         re    hit   dn    ps    tn     rdata         cnt
        tbl[0]  = '{1'b1, 32'h0,       4'h0, 32'h0,       1'b0, 1'b0, 1'b0, 1'b0, 31'd0, 32'h0,       0};
        tbl[1]  = '{1'b0, 32'h1000,    4'hF, 32'h100,     1'b0, 1'b1, 1'b0, 1'b0, 31'd0, 32'h0,       1};
        tbl[2]  = '{1'b0, 32'h1000,    4'h0, 32'h0,       1'b1, 1'b1, 1'b0, 1'b0, 31'd0, 32'h100,     2};
        tbl[3]  = '{1'b0, 32'h1000,    4'h3, 32'h1,       1'b1, 1'b1, 1'b1, 1'b1, 31'd0, 32'h100,     3};
        tbl[4]  = '{1'b0, 32'h0,       4'h0, 32'h0,       1'b0, 1'b0, 1'b1, 1'b1, 31'd0, 32'h100,     3};
        tbl[5]  = '{1'b0, 32'h1000,    4'hF, 32'h7,       1'b0, 1'b1, 1'b1, 1'b1, 31'd0, 32'h100,     3};
        tbl[6]  = '{1'b0, 32'h1004,    4'h0, 32'h0,       1'b1, 1'b1, 1'b1, 1'b1, 31'd0, 32'h1,       3};
        tbl[7]  = '{1'b0, 32'h1000,    4'h0, 32'h0,       1'b1, 1'b1, 1'b1, 1'b1, 31'd0, 32'h1,       3};
        tbl[8]  = '{1'b1, 32'h0,       4'h0, 32'h0,       1'b0, 1'b0, 1'b0, 1'b0, 31'd0, 32'h0,       0};
        tbl[9]  = '{1'b0, 32'h1000,    4'hF, 32'h7,       1'b0, 1'b1, 1'b1, 1'b0, 31'd3, 32'h0,       1};
        tbl[10] = '{1'b0, 32'h1004,    4'h0, 32'h0,       1'b1, 1'b1, 1'b1, 1'b0, 31'd3, 32'h2,       1};
        tbl[11] = '{1'b1, 32'h1000,    4'hF, 32'h1,       1'b0, 1'b1, 1'b0, 1'b0, 31'd0, 32'h0,       0};
        tbl[12] = '{1'b0, 32'h1000,    4'h0, 32'h0,       1'b1, 1'b1, 1'b0, 1'b0, 31'd0, 32'h0,       1};
        tbl[13] = '{1'b0, 32'h1008,    4'hF, 32'h1,       1'b0, 1'b0, 1'b0, 1'b0, 31'd0, 32'h0,       2};
        tbl[14] = '{1'b0, 32'h1004,    4'h0, 32'h0,       1'b1, 1'b1, 1'b0, 1'b0, 31'd0, 32'h0,       3};
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].r, tbl[i].a, tbl[i].w, tbl[i].d, tbl[i].e, h);
            chk($sformatf("tbl%0d_hit", i), h, tbl[i].hit);
            chk($sformatf("tbl%0d_done", i), done, tbl[i].dn);
            chk($sformatf("tbl%0d_pass", i), pass, tbl[i].ps);
            chk($sformatf("tbl%0d_testnum", i), fail_testnum, tbl[i].tn);
            chk($sformatf("tbl%0d_rdata", i), bus.mem_rdata, tbl[i].rd);
            chk($sformatf("tbl%0d_count", i), cycle_count, 64'(tbl[i].cnt));
        end

        // Watchdog: done rises on edge TO exactly (only with the watchdog built in).
        step(1'b1, 32'h0, 4'h0, 32'h0, 1'b0, h);
        idle(TO - 1);
        chk("to_before", done, 1'b0);
        idle(1);
        chk("to_done", done, TO_EN);
        chk("to_count", cycle_count, 64'(TO));
        step(1'b0, ST, 4'h0, 32'h0, 1'b1, h);
        chk("to_status", bus.mem_rdata, TO_EN ? 32'd3 : 32'd0);

        // Store of 1 on the timeout edge wins.
        step(1'b1, 32'h0, 4'h0, 32'h0, 1'b0, h);
        idle(TO - 1);
        step(1'b0, TH, 4'hF, 32'h1, 1'b0, h);
        chk("to_race_pass", pass, 1'b1);
        chk("to_race_done", done, 1'b1);

        // Long idle run: counter saturates unless the watchdog fires first.
        step(1'b1, 32'h0, 4'h0, 32'h0, 1'b0, h);
        idle(300);
        chk("sat_count", cycle_count, TO_EN ? 64'(TO) : 64'(CMAX));

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 3))
                0: a = TH;
                1: a = ST;
                2: a = 32'h1008;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0: d = 32'h1;
                1: d = $urandom & 32'hFF;
                default: d = $urandom;
            endcase
            w = $urandom_range(0, 1) ? 4'hF : 4'($urandom);
            step($urandom_range(0, 24) == 0, a, w, d, 1'($urandom), h);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
